// File: rtl/sdc_wb_arbiter.sv
// Two-master round-robin classic Wishbone arbiter for the SD controller register port.
// The owner keeps the bus while it holds cyc. A per-access watchdog turns a hung slave into err.
module sdc_wb_arbiter #(
  parameter int AW      = 8,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [AW-1:0]   m0_addr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic [AW-1:0]   m1_addr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic [AW-1:0]   s_addr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_we_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  output logic            busy_o
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, ERR} state_t;

  localparam logic [15:0] WD_TC = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [15:0] wd_q, wd_d;

  // last_q always names the current owner once a grant has been made
  logic            own_cyc, own_stb, own_we, own_ack;
  logic [AW-1:0]   own_addr;
  logic [DW-1:0]   own_dat;
  logic [DW/8-1:0] own_sel;

  always_comb begin
    if (last_q) begin
      own_cyc  = m1_cyc_i;
      own_stb  = m1_stb_i;
      own_we   = m1_we_i;
      own_addr = m1_addr_i;
      own_dat  = m1_dat_i;
      own_sel  = m1_sel_i;
    end else begin
      own_cyc  = m0_cyc_i;
      own_stb  = m0_stb_i;
      own_we   = m0_we_i;
      own_addr = m0_addr_i;
      own_dat  = m0_dat_i;
      own_sel  = m0_sel_i;
    end
  end

  // An ack arriving while the owner drops cyc is swallowed.
  assign own_ack = s_ack_i & own_stb & own_cyc;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    wd_d     = '0;
    s_addr_o = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_we_o   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
          state_d = OWN0;
          last_d  = 1'b0;
        end else if (m1_cyc_i) begin
          state_d = OWN1;
          last_d  = 1'b1;
        end
      end
      OWN0, OWN1: begin
        s_addr_o = own_addr;
        s_dat_o  = own_dat;
        s_sel_o  = own_sel;
        s_we_o   = own_we;
        s_cyc_o  = own_cyc;
        s_stb_o  = own_stb;
        if (last_q) begin
          m1_ack_o = own_ack;
          m1_dat_o = s_dat_i;
        end else begin
          m0_ack_o = own_ack;
          m0_dat_o = s_dat_i;
        end
        // Ack on the terminal-count cycle wins over the timeout.
        if (!own_cyc) begin
          state_d = IDLE;
        end else if (own_stb && !s_ack_i) begin
          if (wd_q == WD_TC) state_d = ERR;
          else               wd_d    = wd_q + 16'd1;
        end
      end
      ERR: begin
        if (last_q) m1_err_o = 1'b1;
        else        m0_err_o = 1'b1;
        if (own_cyc) state_d = last_q ? OWN1 : OWN0;
        else         state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q != IDLE);

endmodule
